// File: rtl/kenel_tutorial_example_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// kenel_tutorial_example_ctrl_pkg
//   Shared definitions for the vadd kernel AXI4-Lite control slave:
//   register offsets (decoded on addr[5:0]), CTRL bit positions, and the
//   write/read channel state encodings.
//   Helper: apply_wstrb merges write data into a 32-bit register per byte lane.
// -----------------------------------------------------------------------------
package kenel_tutorial_example_ctrl_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_GIE    = 6'h04;
  localparam logic [5:0] ADDR_IER    = 6'h08;
  localparam logic [5:0] ADDR_ISR    = 6'h0C;
  localparam logic [5:0] ADDR_PTR0_L = 6'h10;
  localparam logic [5:0] ADDR_PTR0_H = 6'h14;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_IDLE_BIT  = 2;
  localparam int CTRL_READY_BIT = 3;
  localparam int CTRL_AUTO_BIT  = 7;

  typedef enum logic [1:0] {
    WRIDLE = 2'd0,
    WRDATA = 2'd1,
    WRRESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    RDIDLE = 1'b0,
    RDDATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kenel_tutorial_example_control_s_axi.sv
// -----------------------------------------------------------------------------
// kenel_tutorial_example_control_s_axi
//   AXI4-Lite control slave for the vadd RTL kernel. The host programs the
//   register map; this block drives ap_start / axi00_ptr0 to the kernel and
//   collects ap_done / ap_idle / ap_ready into status and interrupt bits.
// Ports
//   ap_clk, areset             clock, synchronous active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b*   write address / data / response channels
//   s_axi_ar* / s_axi_r*              read address / data channels
//   interrupt                  GIE & |ISR (level)
//   ap_start                   level start to the kernel
//   ap_done, ap_idle, ap_ready kernel status inputs (pulse, level, pulse)
//   axi00_ptr0                 64-bit buffer base address
// -----------------------------------------------------------------------------
module kenel_tutorial_example_control_s_axi
  import kenel_tutorial_example_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [1:0]                      s_axi_bresp,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            interrupt,
  output logic                            ap_start,
  input  logic                            ap_done,
  input  logic                            ap_idle,
  input  logic                            ap_ready,
  output logic [63:0]                     axi00_ptr0
);

  wr_state_t   wr_state_reg;
  rd_state_t   rd_state_reg;
  logic [5:0]  waddr_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;

  logic        ap_start_reg;
  logic        auto_restart_reg;
  logic        done_reg;
  logic        ready_reg;
  logic        gie_reg;
  logic [1:0]  ier_reg;
  logic [1:0]  isr_reg;
  logic [31:0] ptr0_l_reg;
  logic [31:0] ptr0_h_reg;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic [5:0]  raddr;
  logic        wr_ctrl;
  logic        wr_isr;
  logic        unused_addr_bits;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign raddr = s_axi_araddr[5:0];

  // Only the low six address bits select a register.
  assign unused_addr_bits = ^{s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:6],
                              s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:6]};

  // Channel handshakes are pure decodes of the state so the reset values
  // (awready/arready high, valids low) fall out of the IDLE states.
  assign s_axi_awready = (wr_state_reg == WRIDLE);
  assign s_axi_wready  = (wr_state_reg == WRDATA);
  assign s_axi_bvalid  = (wr_state_reg == WRRESP);
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = (rd_state_reg == RDIDLE);
  assign s_axi_rvalid  = (rd_state_reg == RDDATA);
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = 2'b00;

  assign interrupt  = gie_reg & (|isr_reg);
  assign ap_start   = ap_start_reg;
  assign axi00_ptr0 = {ptr0_h_reg, ptr0_l_reg};

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_state_reg <= WRIDLE;
      waddr_reg    <= '0;
    end else begin
      case (wr_state_reg)
        WRIDLE: if (aw_hs) begin
          wr_state_reg <= WRDATA;
          waddr_reg    <= s_axi_awaddr[5:0];
        end
        WRDATA: if (s_axi_wvalid) wr_state_reg <= WRRESP;
        WRRESP: if (s_axi_bready) wr_state_reg <= WRIDLE;
        default: wr_state_reg <= WRIDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rd_state_reg <= RDIDLE;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        RDIDLE: if (ar_hs) begin
          rd_state_reg <= RDDATA;
          rdata_reg    <= rdata_next;
        end
        RDDATA: if (s_axi_rready) rd_state_reg <= RDIDLE;
        default: rd_state_reg <= RDIDLE;
      endcase
    end
  end

  always_comb begin
    rdata_next = '0;
    case (raddr)
      ADDR_CTRL: begin
        rdata_next[CTRL_START_BIT] = ap_start_reg;
        rdata_next[CTRL_DONE_BIT]  = done_reg;
        rdata_next[CTRL_IDLE_BIT]  = ap_idle;
        rdata_next[CTRL_READY_BIT] = ready_reg;
        rdata_next[CTRL_AUTO_BIT]  = auto_restart_reg;
      end
      ADDR_GIE:    rdata_next[0]   = gie_reg;
      ADDR_IER:    rdata_next[1:0] = ier_reg;
      ADDR_ISR:    rdata_next[1:0] = isr_reg;
      ADDR_PTR0_L: rdata_next      = ptr0_l_reg;
      ADDR_PTR0_H: rdata_next      = ptr0_h_reg;
      default:     rdata_next      = '0;
    endcase
  end

  // ------------------------------------------------------------ register file
  assign wr_ctrl = w_hs && (waddr_reg == ADDR_CTRL) && s_axi_wstrb[0];
  assign wr_isr  = w_hs && (waddr_reg == ADDR_ISR)  && s_axi_wstrb[0];

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start_reg     <= 1'b0;
      auto_restart_reg <= 1'b0;
      done_reg         <= 1'b0;
      ready_reg        <= 1'b0;
      gie_reg          <= 1'b0;
      ier_reg          <= '0;
      isr_reg          <= '0;
      ptr0_l_reg       <= '0;
      ptr0_h_reg       <= '0;
    end else begin
      // A host start request wins over a same-cycle ap_ready clear.
      if (wr_ctrl && s_axi_wdata[CTRL_START_BIT])
        ap_start_reg <= 1'b1;
      else if (ap_ready && !auto_restart_reg)
        ap_start_reg <= 1'b0;

      if (wr_ctrl) auto_restart_reg <= s_axi_wdata[CTRL_AUTO_BIT];

      // Clear-on-read status: a pulse arriving with the read is kept.
      if (ap_done)
        done_reg <= 1'b1;
      else if (ar_hs && raddr == ADDR_CTRL)
        done_reg <= 1'b0;

      if (ap_ready)
        ready_reg <= 1'b1;
      else if (ar_hs && raddr == ADDR_CTRL)
        ready_reg <= 1'b0;

      if (w_hs && waddr_reg == ADDR_GIE && s_axi_wstrb[0]) gie_reg <= s_axi_wdata[0];
      if (w_hs && waddr_reg == ADDR_IER && s_axi_wstrb[0]) ier_reg <= s_axi_wdata[1:0];

      // Interrupt events override a same-cycle toggle so none is lost.
      if (ier_reg[0] && ap_done)
        isr_reg[0] <= 1'b1;
      else if (wr_isr)
        isr_reg[0] <= isr_reg[0] ^ s_axi_wdata[0];

      if (ier_reg[1] && ap_ready)
        isr_reg[1] <= 1'b1;
      else if (wr_isr)
        isr_reg[1] <= isr_reg[1] ^ s_axi_wdata[1];

      if (w_hs && waddr_reg == ADDR_PTR0_L)
        ptr0_l_reg <= apply_wstrb(ptr0_l_reg, s_axi_wdata, s_axi_wstrb);
      if (w_hs && waddr_reg == ADDR_PTR0_H)
        ptr0_h_reg <= apply_wstrb(ptr0_h_reg, s_axi_wdata, s_axi_wstrb);
    end
  end

endmodule

// File: tb/tb_kenel_tutorial_example_control_s_axi.sv
// -----------------------------------------------------------------------------
// tb_kenel_tutorial_example_control_s_axi
//   Self-checking bench for the vadd AXI4-Lite control slave. A register-level
//   model (plain variables updated per bus transaction / kernel pulse) supplies
//   every expected value. Directed scenarios first, then random traffic.
// -----------------------------------------------------------------------------
module tb_kenel_tutorial_example_control_s_axi;

  localparam int WAIT_MAX = 20;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        s_axi_awvalid, s_axi_awready;
  logic [11:0] s_axi_awaddr;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [11:0] s_axi_araddr;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        interrupt, ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [63:0] axi00_ptr0;

  int checks = 0;
  int errors = 0;

  // register-level reference state
  logic        m_start, m_auto, m_done, m_ready, m_gie;
  logic [1:0]  m_ier, m_isr;
  logic [63:0] m_ptr;

  always #5 ap_clk = ~ap_clk;

  kenel_tutorial_example_control_s_axi #(
    .C_S_AXI_ADDR_WIDTH(12),
    .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .ap_clk(ap_clk), .areset(areset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .interrupt(interrupt), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .axi00_ptr0(axi00_ptr0)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  task automatic model_reset();
    m_start = 0; m_auto = 0; m_done = 0; m_ready = 0; m_gie = 0;
    m_ier = 0; m_isr = 0; m_ptr = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a[5:0])
      6'h00: return {24'b0, m_auto, 3'b0, m_ready, ap_idle, m_done, m_start};
      6'h04: return {31'b0, m_gie};
      6'h08: return {30'b0, m_ier};
      6'h0C: return {30'b0, m_isr};
      6'h10: return m_ptr[31:0];
      6'h14: return m_ptr[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[5:0])
      6'h00: if (s[0]) begin
        if (d[0]) m_start = 1;
        m_auto = d[7];
      end
      6'h04: if (s[0]) m_gie = d[0];
      6'h08: if (s[0]) m_ier = d[1:0];
      6'h0C: if (s[0]) m_isr = m_isr ^ d[1:0];
      6'h10: for (int b = 0; b < 4; b++) if (s[b]) m_ptr[b*8 +: 8] = d[b*8 +: 8];
      6'h14: for (int b = 0; b < 4; b++) if (s[b]) m_ptr[32 + b*8 +: 8] = d[b*8 +: 8];
      default: ;
    endcase
  endtask

  // Kernel events are applied after any same-cycle host action (events win).
  task automatic model_event(input logic d, input logic r);
    if (d) m_done = 1;
    if (r) m_ready = 1;
    if (r && !m_auto) m_start = 0;
    if (d && m_ier[0]) m_isr[0] = 1;
    if (r && m_ier[1]) m_isr[1] = 1;
  endtask

  task automatic check_outputs(input string tag);
    check_value({tag, "_ap_start"}, ap_start, m_start);
    check_value({tag, "_interrupt"}, interrupt, m_gie & (|m_isr));
    check_value({tag, "_ptr0"}, axi00_ptr0, m_ptr);
  endtask

  // ---------------------------------------------------------------- bus tasks
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic done_pulse);
    int n;
    @(negedge ap_clk);
    s_axi_awvalid = 1; s_axi_awaddr = a;
    n = 0;
    while (!s_axi_awready && n < WAIT_MAX) begin @(negedge ap_clk); n++; end
    check_value("wr_awready_wait", s_axi_awready, 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_axi_awvalid = 0;
    s_axi_wvalid = 1; s_axi_wdata = d; s_axi_wstrb = s; ap_done = done_pulse;
    n = 0;
    while (!s_axi_wready && n < WAIT_MAX) begin @(negedge ap_clk); n++; end
    check_value("wr_wready_wait", s_axi_wready, 1);
    @(posedge ap_clk);
    model_write(a, d, s);
    model_event(done_pulse, 1'b0);
    @(negedge ap_clk);
    s_axi_wvalid = 0; ap_done = 0;
    check_outputs("wr");
    s_axi_bready = 1;
    n = 0;
    while (!s_axi_bvalid && n < WAIT_MAX) begin @(negedge ap_clk); n++; end
    check_value("wr_bvalid_wait", s_axi_bvalid, 1);
    check_value("wr_bresp", s_axi_bresp, 2'b00);
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_axi_bready = 0;
    check_value("wr_bvalid_drop", s_axi_bvalid, 0);
    $display("WR  addr=%h data=%h strb=%h done=%0d", a, d, s, done_pulse);
  endtask

  task automatic axi_read(input logic [11:0] a, input logic done_pulse, input int hold,
                          output logic [31:0] got);
    int n;
    logic [31:0] exp;
    @(negedge ap_clk);
    s_axi_arvalid = 1; s_axi_araddr = a; ap_done = done_pulse;
    n = 0;
    while (!s_axi_arready && n < WAIT_MAX) begin @(negedge ap_clk); n++; end
    check_value("rd_arready_wait", s_axi_arready, 1);
    exp = model_read(a);
    @(posedge ap_clk);
    if (a[5:0] == 6'h00) begin m_done = 0; m_ready = 0; end
    model_event(done_pulse, 1'b0);
    @(negedge ap_clk);
    s_axi_arvalid = 0; ap_done = 0;
    for (int i = 0; i < hold; i++) begin
      check_value("rd_hold_rvalid", s_axi_rvalid, 1);
      check_value("rd_hold_arready", s_axi_arready, 0);
      check_value("rd_hold_rdata", s_axi_rdata, exp);
      @(negedge ap_clk);
    end
    s_axi_rready = 1;
    n = 0;
    while (!s_axi_rvalid && n < WAIT_MAX) begin @(negedge ap_clk); n++; end
    check_value("rd_rvalid_wait", s_axi_rvalid, 1);
    check_value("rd_rdata", s_axi_rdata, exp);
    check_value("rd_rresp", s_axi_rresp, 2'b00);
    got = s_axi_rdata;
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_axi_rready = 0;
    check_value("rd_rvalid_drop", s_axi_rvalid, 0);
    $display("RD  addr=%h data=%h exp=%h done=%0d hold=%0d", a, got, exp, done_pulse, hold);
  endtask

  task automatic pulse_ap(input logic d, input logic r);
    @(negedge ap_clk);
    ap_done = d; ap_ready = r;
    @(posedge ap_clk);
    model_event(d, r);
    @(negedge ap_clk);
    ap_done = 0; ap_ready = 0;
    check_outputs("ev");
    $display("EV  done=%0d ready=%0d", d, r);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] rd;
    logic [11:0] addr_tbl [8];
    logic [11:0] a;

    addr_tbl[0] = 12'h000; addr_tbl[1] = 12'h004; addr_tbl[2] = 12'h008; addr_tbl[3] = 12'h00C;
    addr_tbl[4] = 12'h010; addr_tbl[5] = 12'h014; addr_tbl[6] = 12'h020; addr_tbl[7] = 12'h03C;

    areset = 1;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_rready = 0;
    ap_done = 0; ap_idle = 0; ap_ready = 0;
    model_reset();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_value("rst_awready", s_axi_awready, 1);
    check_value("rst_arready", s_axi_arready, 1);
    check_value("rst_bvalid", s_axi_bvalid, 0);
    check_value("rst_rvalid", s_axi_rvalid, 0);
    check_value("rst_rdata", s_axi_rdata, 0);
    check_value("rst_interrupt", interrupt, 0);
    check_value("rst_ap_start", ap_start, 0);
    check_value("rst_ptr0", axi00_ptr0, 0);
    areset = 0;

    // 1: pointer programming
    axi_write(12'h010, 32'h89ABC000, 4'hF, 0);
    axi_write(12'h014, 32'h00000001, 4'hF, 0);
    check_value("t1_ptr0", axi00_ptr0, 64'h0000_0001_89AB_C000);

    // 2: single byte lane
    axi_write(12'h010, 32'hFFFFFFFF, 4'h2, 0);
    check_value("t2_ptr0", axi00_ptr0, 64'h0000_0001_89AB_FF00);

    // 3: start / ready / done status
    axi_write(12'h000, 32'h1, 4'hF, 0);
    check_value("t3_start_set", ap_start, 1);
    pulse_ap(0, 1);
    check_value("t3_start_clr", ap_start, 0);
    ap_idle = 1;
    axi_read(12'h000, 0, 0, rd);
    pulse_ap(1, 0);
    axi_read(12'h000, 0, 0, rd);
    check_value("t3_ctrl_first", rd, 32'h6);
    axi_read(12'h000, 0, 0, rd);
    check_value("t3_ctrl_second", rd, 32'h4);

    // 4: interrupt path
    axi_write(12'h004, 32'h1, 4'hF, 0);
    axi_write(12'h008, 32'h1, 4'hF, 0);
    pulse_ap(1, 0);
    check_value("t4_irq_set", interrupt, 1);
    axi_write(12'h00C, 32'h1, 4'hF, 0);
    check_value("t4_irq_clr", interrupt, 0);
    pulse_ap(1, 0);
    axi_write(12'h00C, 32'h1, 4'hF, 1);
    axi_read(12'h00C, 0, 0, rd);
    check_value("t4_isr_set_wins", rd, 32'h1);
    axi_read(12'h000, 1, 0, rd);   // clear-on-read with same-cycle done
    axi_read(12'h000, 0, 0, rd);
    check_value("t4_cor_set_wins", rd[1], 1'b1);

    // 5: auto restart and stalled read
    axi_write(12'h000, 32'h81, 4'hF, 0);
    pulse_ap(0, 1);
    check_value("t5_auto_start", ap_start, 1);
    axi_read(12'h020, 0, 5, rd);
    check_value("t5_unmapped", rd, 32'h0);

    // 6: reset while a write response is pending
    @(negedge ap_clk);
    s_axi_awvalid = 1; s_axi_awaddr = 12'h014;
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_axi_awvalid = 0; s_axi_wvalid = 1; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
    @(posedge ap_clk);
    @(negedge ap_clk);
    s_axi_wvalid = 0;
    check_value("t6_in_wrresp", s_axi_bvalid, 1);
    areset = 1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    areset = 0;
    model_reset();
    ap_idle = 0;
    check_value("t6_bvalid", s_axi_bvalid, 0);
    check_value("t6_awready", s_axi_awready, 1);
    check_outputs("t6");
    $display("RST during WRRESP");
    for (int i = 0; i < 6; i++) begin
      axi_read(addr_tbl[i], 0, 0, rd);
      check_value("t6_reg_zero", rd, 32'h0);
    end

    // random traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = addr_tbl[$urandom_range(0, 7)];
          axi_write(a, $urandom, 4'($urandom), 1'($urandom));
        end
        1: begin
          a = addr_tbl[$urandom_range(0, 7)];
          axi_read(a, 1'($urandom), $urandom_range(0, 3), rd);
        end
        2: pulse_ap(1'($urandom), 1'($urandom));
        default: begin
          ap_idle = ~ap_idle;
          $display("IDL ap_idle=%0d", ap_idle);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
